// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 16-bit words over a req/ack memory
// handshake into a 2-entry prefetch buffer and loads the instruction
// register on demand from the controller's control word.
//
// Memory handshake: mem_req is registered and, once raised, stays high with
// mem_addr frozen until the cycle in which mem_ack=1 (that cycle may be the
// first one mem_req is high); only a reset withdraws a request early.
// mem_rdata is consumed only in a cycle with mem_req=1 and mem_ack=1.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              ir_load,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [15:0]       IRF_val,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              ir_stall,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;  // no request outstanding
  localparam logic [1:0] S_WAIT   = 2'd1;  // request outstanding, data kept
  localparam logic [1:0] S_DROP   = 2'd2;  // request outstanding, data discarded
  localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [15:0]       r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_addr [2];

  logic [15:0]       r_ir_data;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;

  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_nxt;
  logic              w_room;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;

  // An ack only means something while our request is up.
  assign w_ack    = mem_ack & r_mem_req;
  // Only WAIT keeps returned data; a redirect in the ack cycle discards it.
  assign w_push   = w_ack & (r_state == S_WAIT) & ~pc_load;
  // A redirect wins over an IR load; the load is simply ignored.
  assign w_pop    = ir_load & ~pc_load & (r_count != 2'd0);
  assign ir_stall = ir_load & ~pc_load & (r_count == 2'd0);
  // Occupancy after this cycle's flush/push/pop; a new request is only
  // issued when the word it returns is guaranteed a free slot.
  assign w_count_nxt = pc_load ? 2'd0
                     : (r_count + {1'b0, w_push} - {1'b0, w_pop});
  assign w_room   = (w_count_nxt < LP_DEPTH);
  assign w_pc_inc = r_fetch_pc + ADDR_W'(1);

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (rstn) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Fetch FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!pc_load && w_room) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_ack) begin
          if (!pc_load && !w_room) w_state_nxt = S_IDLE;
        end else if (pc_load) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (w_ack) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch FSM outputs: next request/address and next fetch pointer.
  always_comb begin
    w_req_nxt      = r_mem_req;
    w_addr_nxt     = r_mem_addr;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (pc_load) begin
          w_fetch_pc_nxt = pc_load_val;
        end else if (w_room) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (pc_load) begin
          // Redirect: if the old request completes now, start the new one.
          w_fetch_pc_nxt = pc_load_val;
          if (w_ack) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = pc_load_val;
          end
        end else if (w_ack) begin
          w_fetch_pc_nxt = w_pc_inc;
          if (w_room) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_pc_inc;
          end else begin
            w_req_nxt  = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (pc_load) w_fetch_pc_nxt = pc_load_val;
        // fetch_pc already holds the redirect target.
        if (w_ack) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = pc_load ? pc_load_val : r_fetch_pc;
        end
      end
      default: w_req_nxt = 1'b0;
    endcase
  end

  // Request registers, fetch pointer and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_mem_req  <= w_req_nxt;
      r_mem_addr <= w_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_count    <= w_count_nxt;
      if (pc_load) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Prefetch buffer storage: word plus the address it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= mem_rdata;
      r_buf_addr[r_wr_ptr] <= r_mem_addr;
    end
  end

  // Instruction register load from the buffer head.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_ir_data  <= 16'h0000;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_pop) begin
      r_ir_data  <= r_buf_data[r_rd_ptr];
      r_ir_pc    <= r_buf_addr[r_rd_ptr];
      r_ir_valid <= 1'b1;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign IRF_val     = r_ir_data;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: latency-configurable memory responder,
// a reference model of buffer and IR contents, and directed scenarios.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ir_load;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] IRF_val;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_stall;
  logic [1:0]  o_dbg_state;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_load(ir_load), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .IRF_val(IRF_val), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_stall(ir_stall), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // memory responder controls and observations
  int          lat = 0;
  logic [15:0] slow_addr = 16'h7777;
  int          slow_lat = 0;
  logic [15:0] ack_log[$];
  logic [15:0] ack_addr;
  logic        req_s = 1'b0;
  logic [15:0] addr_s = 16'h0000;

  // reference model: buffer of {addr,data}, expected IR loads, stale flag
  logic [31:0] buf_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_ir = 32'h0;
  logic        m_valid = 1'b0;
  logic        stale = 1'b0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA001 + a;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < ack_log.size()) return {16'h0, ack_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1; ir_load = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;
    @(negedge clk);
    rstn = 1'b0;
    ack_log.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"},   mem_req, 0);
    check_eq({tag, "_addr"},  mem_addr, 0);
    check_eq({tag, "_irf"},   IRF_val, 0);
    check_eq({tag, "_irpc"},  ir_pc, 0);
    check_eq({tag, "_valid"}, ir_valid, 0);
    check_eq({tag, "_state"}, o_dbg_state, 0);
  endtask

  // memory responder: ack after 'lat' extra cycles per request
  initial begin
    logic new_req;
    int   wait_cnt;
    new_req = 1'b1; wait_cnt = 0;
    mem_ack = 1'b0; mem_rdata = 16'h0; ack_addr = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      req_s   = mem_req;
      addr_s  = mem_addr;
      if (!mem_req) begin
        new_req = 1'b1;
      end else begin
        if (new_req) begin
          wait_cnt = (mem_addr == slow_addr) ? slow_lat : lat;
          new_req  = 1'b0;
        end
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_addr  = mem_addr;
          ack_log.push_back(mem_addr);
          new_req   = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // scoreboard: model buffer/IR at each edge, compare IR and handshake after
  initial begin
    logic hold;
    forever begin
      @(posedge clk);
      hold = 1'b0;
      if (rstn) begin
        buf_q.delete(); exp_q.delete();
        stale = 1'b0; m_ir = 32'h0; m_valid = 1'b0;
      end else begin
        hold = req_s && !mem_ack;
        if (ir_load && !pc_load && buf_q.size() > 0) exp_q.push_back(buf_q.pop_front());
        if (pc_load) buf_q.delete();
        else if (mem_ack && !stale) buf_q.push_back({ack_addr, mem_rdata});
        if (mem_ack) stale = 1'b0;
        else if (pc_load && req_s) stale = 1'b1;
      end
      #1;
      if (exp_q.size() > 0) begin
        m_ir = exp_q.pop_front();
        m_valid = 1'b1;
      end
      check_eq("ir", {ir_pc, IRF_val}, m_ir);
      check_eq("ir_valid", ir_valid, m_valid);
      if (hold) begin
        check_eq("req_hold", mem_req, 1);
        check_eq("addr_hold", mem_addr, addr_s);
      end
    end
  end

  // stall flag against model occupancy, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) check_eq("stall", ir_stall, ir_load && !pc_load && (buf_q.size() == 0));
    end
  end

  // directed scenarios
  initial begin
    int ack_cyc;
    int val_cyc;
    bit found;
    rstn = 1'b1; ir_load = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;

    // zero-latency fill with ir_load low
    lat = 0;
    do_reset();
    #1;
    check_reset_vals("t1_rst");
    repeat (10) @(negedge clk);
    #1;
    check_eq("t1_nlog", ack_log.size(), 2);
    check_eq("t1_log0", log_at(0), 32'h0000);
    check_eq("t1_log1", log_at(1), 32'h0001);
    check_eq("t1_req_low", mem_req, 0);
    check_eq("t1_valid", ir_valid, 0);

    // two IR loads, then refetch from address 2
    ir_load = 1'b1; @(negedge clk);
    ir_load = 1'b0; @(negedge clk);
    ir_load = 1'b1; @(negedge clk);
    ir_load = 1'b0;
    #1;
    check_eq("t2_irf", IRF_val, 16'hA002);
    check_eq("t2_irpc", ir_pc, 16'h0001);
    repeat (6) @(negedge clk);
    #1;
    check_eq("t2_nlog", ack_log.size(), 4);
    check_eq("t2_log2", log_at(2), 32'h0002);
    check_eq("t2_log3", log_at(3), 32'h0003);

    // ir_load held from reset, 3-cycle ack latency
    lat = 3;
    do_reset();
    ir_load = 1'b1;
    ack_cyc = -1; val_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (ack_cyc < 0 && ack_log.size() > 0) ack_cyc = i;
      if (ir_valid) begin
        val_cyc = i;
        break;
      end
    end
    // ack cycle pushes, next cycle pops, IR visible the cycle after that
    check_eq("t3_ack_seen", ack_cyc >= 0, 1);
    check_eq("t3_load_delay", val_cyc - ack_cyc, 2);
    check_eq("t3_irf", IRF_val, 16'hA001);
    check_eq("t3_irpc", ir_pc, 16'h0000);
    ir_load = 1'b0;

    // redirect while the request for address 5 is outstanding
    lat = 0; slow_addr = 16'h0005; slow_lat = 2;
    do_reset();
    ir_load = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_addr == 16'h0005) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t4_found5", found, 1);
    pc_load = 1'b1; pc_load_val = 16'h0040; ir_load = 1'b0;
    @(negedge clk);
    pc_load = 1'b0; ir_load = 1'b1;
    #2;
    check_eq("t4_empty_stall", ir_stall, 1);
    check_eq("t4_addr_held", mem_addr, 16'h0005);
    check_eq("t4_req_held", mem_req, 1);
    repeat (4) @(negedge clk);
    #1;
    check_eq("t4_log5", log_at(5), 32'h0005);
    check_eq("t4_log6", log_at(6), 32'h0040);
    ir_load = 1'b0;
    slow_addr = 16'h7777;

    // address wrap at 0xFFFF
    lat = 1;
    do_reset();
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    @(negedge clk);
    pc_load = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check_eq("t5_nlog", ack_log.size(), 2);
    check_eq("t5_log0", log_at(0), 32'hFFFF);
    check_eq("t5_log1", log_at(1), 32'h0000);
    ir_load = 1'b1; @(negedge clk);
    ir_load = 1'b0; @(negedge clk);
    ir_load = 1'b1; @(negedge clk);
    ir_load = 1'b0;
    #1;
    check_eq("t5_irpc", ir_pc, 16'h0000);
    check_eq("t5_irf", IRF_val, 16'hA001);

    // pc_load and ir_load together with a full buffer, then reset mid-WAIT
    lat = 0;
    do_reset();
    repeat (6) @(negedge clk);
    ir_load = 1'b1; @(negedge clk);
    ir_load = 1'b0;
    repeat (4) @(negedge clk);
    pc_load = 1'b1; pc_load_val = 16'h0100; ir_load = 1'b1;
    #2;
    check_eq("t6_no_stall", ir_stall, 0);
    @(negedge clk);
    pc_load = 1'b0; ir_load = 1'b0; lat = 3;
    #1;
    check_eq("t6_irf", IRF_val, 16'hA001);
    check_eq("t6_irpc", ir_pc, 16'h0000);
    check_eq("t6_valid", ir_valid, 1);
    @(negedge clk);
    #1;
    check_eq("t6_req", mem_req, 1);
    check_eq("t6_addr", mem_addr, 16'h0100);
    check_eq("t6_state", o_dbg_state, 1);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
